// File: rtl/line_fetch_arbiter.sv
// Framebuffer port arbiter for a 720p upscaler. During the horizontal blank
// it reads one 320-pixel source row into a line-buffer bank. At all other
// times the port serves renderer writes.
module line_fetch_arbiter #(
    parameter int PIXEL_WIDTH = 16,
    parameter int FB_LATENCY  = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   wr_valid_in,
    input  logic [15:0]            wr_addr_in,
    input  logic [PIXEL_WIDTH-1:0] wr_data_in,
    output logic                   wr_ready_out,
    output logic [15:0]            fb_addr_out,
    output logic                   fb_we_out,
    output logic [PIXEL_WIDTH-1:0] fb_din_out,
    input  logic [PIXEL_WIDTH-1:0] fb_dout_in,
    output logic                   lb_we_out,
    output logic                   lb_bank_out,
    output logic [8:0]             lb_addr_out,
    output logic [PIXEL_WIDTH-1:0] lb_data_out,
    output logic                   disp_bank_out,
    output logic                   overrun_out
);

    localparam int unsigned LAT     = FB_LATENCY;
    localparam int unsigned CNT_W   = (FB_LATENCY > 1) ? $clog2(FB_LATENCY) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(FB_LATENCY - 1);
    localparam logic [15:0]  FB_WORDS = 16'd57600;
    localparam logic [8:0]   LAST_COL = 9'd319;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                 state;
    logic [15:0]            base;
    logic [8:0]             col;
    logic                   fill_bank;
    logic [CNT_W-1:0]       drain_cnt;

    logic [LAT-1:0]         pipe_valid;
    logic [LAT-1:0]         pipe_bank;
    logic [8:0]             pipe_col [LAT];

    logic                   trigger;
    logic [7:0]             fetch_row;
    logic [15:0]            row_base;
    logic                   wr_accept;
    logic [15:0]            addr_q;
    logic [PIXEL_WIDTH-1:0] din_q;

    // Fetch trigger decode and row base address (row*320 = row*256 + row*64)
    always_comb begin
        trigger   = (hcount_in == 11'd1280) &&
                    (((vcount_in[1:0] == 2'd3) && (vcount_in < 10'd719)) ||
                     (vcount_in == 10'd749));
        fetch_row = (vcount_in == 10'd749) ? 8'd0 : 8'((vcount_in + 10'd1) >> 2);
        row_base  = {fetch_row, 8'd0} + {2'd0, fetch_row, 6'd0};
    end

    // Port mux: a fetch read owns the port, otherwise an accepted write;
    // when neither is active the last address/data are held.
    always_comb begin
        wr_ready_out  = (state == IDLE) && !trigger && !rst_in;
        wr_accept     = wr_valid_in && wr_ready_out;
        fb_we_out     = wr_accept && (wr_addr_in < FB_WORDS);
        fb_din_out    = wr_accept ? wr_data_in : din_q;
        if (state == FETCH)
            fb_addr_out = base + {7'd0, col};
        else if (wr_accept)
            fb_addr_out = wr_addr_in;
        else
            fb_addr_out = addr_q;
        disp_bank_out = vcount_in[2];
        lb_we_out     = pipe_valid[LAT-1];
        lb_bank_out   = pipe_bank[LAT-1];
        lb_addr_out   = pipe_col[LAT-1];
        lb_data_out   = fb_dout_in;
    end

    // Hold the last port address/data between transactions
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            addr_q <= fb_addr_out;
            din_q  <= fb_din_out;
        end
    end

    // Fetch FSM: IDLE -> FETCH (320 reads) -> DRAIN (read latency) -> IDLE
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            base        <= '0;
            col         <= '0;
            fill_bank   <= 1'b0;
            drain_cnt   <= '0;
            overrun_out <= 1'b0;
        end else begin
            if (trigger && (state != IDLE))
                overrun_out <= 1'b1;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state     <= FETCH;
                        base      <= row_base;
                        col       <= '0;
                        fill_bank <= fetch_row[0];
                    end
                end
                FETCH: begin
                    if (col == LAST_COL) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        col <= col + 9'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST)
                        state <= IDLE;
                    else
                        drain_cnt <= drain_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Delay each read's column and bank by the framebuffer latency so the
    // line-buffer write lines up with the returning data.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pipe_valid <= '0;
            pipe_bank  <= '0;
            for (int unsigned i = 0; i < LAT; i++)
                pipe_col[i] <= '0;
        end else begin
            pipe_valid[0] <= (state == FETCH);
            pipe_bank[0]  <= fill_bank;
            pipe_col[0]   <= col;
            for (int unsigned i = 1; i < LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_bank[i]  <= pipe_bank[i-1];
                pipe_col[i]   <= pipe_col[i-1];
            end
        end
    end

endmodule

// File: tb/tb_line_fetch_arbiter.sv
// Scoreboard bench for line_fetch_arbiter: a behavioural framebuffer with read
// latency sits on the port, a reference copy tracks expected contents, and the
// expected line-buffer writes are queued whenever a fetch is triggered.
module tb_line_fetch_arbiter;

    localparam int PW    = 16;
    localparam int LAT   = 2;
    localparam int WORDS = 57600;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [10:0]   hcount_in;
    logic [9:0]    vcount_in;
    logic          wr_valid_in;
    logic [15:0]   wr_addr_in;
    logic [PW-1:0] wr_data_in;
    logic          wr_ready_out;
    logic [15:0]   fb_addr_out;
    logic          fb_we_out;
    logic [PW-1:0] fb_din_out;
    logic [PW-1:0] fb_dout_in;
    logic          lb_we_out;
    logic          lb_bank_out;
    logic [8:0]    lb_addr_out;
    logic [PW-1:0] lb_data_out;
    logic          disp_bank_out;
    logic          overrun_out;

    line_fetch_arbiter #(.PIXEL_WIDTH(PW), .FB_LATENCY(LAT)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .wr_valid_in(wr_valid_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
        .wr_ready_out(wr_ready_out), .fb_addr_out(fb_addr_out), .fb_we_out(fb_we_out),
        .fb_din_out(fb_din_out), .fb_dout_in(fb_dout_in), .lb_we_out(lb_we_out),
        .lb_bank_out(lb_bank_out), .lb_addr_out(lb_addr_out), .lb_data_out(lb_data_out),
        .disp_bank_out(disp_bank_out), .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    logic [PW-1:0] fb_mem  [WORDS];
    logic [PW-1:0] ref_mem [WORDS];
    logic [PW-1:0] rd_pipe [LAT];
    bit            mem_ready = 1'b0;
    logic [31:0]   lbq [$];
    int            n_checks = 0;
    int            n_pass   = 0;

    function automatic logic [PW-1:0] seed_pix(input int a);
        return PW'((a * 40503) ^ 32'h5a5a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Framebuffer with FB_LATENCY-cycle read data
    always @(posedge clk_in) begin
        if (!mem_ready) begin
            for (int i = 0; i < WORDS; i++)
                fb_mem[i] <= seed_pix(i);
            mem_ready <= 1'b1;
        end else if (fb_we_out) begin
            fb_mem[fb_addr_out] <= fb_din_out;
        end
        rd_pipe[0] <= (int'(fb_addr_out) < WORDS) ? fb_mem[fb_addr_out] : '0;
        for (int i = 1; i < LAT; i++)
            rd_pipe[i] <= rd_pipe[i-1];
    end
    assign fb_dout_in = rd_pipe[LAT-1];

    // Line-buffer write monitor: pops the scoreboard
    always @(negedge clk_in) begin
        if (lb_we_out === 1'b1) begin
            check("lb_bank_vs_disp", 32'(lb_bank_out != disp_bank_out), 32'd1);
            if (lbq.size() == 0)
                check("lb_unexpected", 32'd1, 32'd0);
            else
                check("lb_write", {6'd0, lb_bank_out, lb_addr_out, lb_data_out}, lbq.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_writes(input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] a;
            logic        v;
            v = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 9) == 0) ? 16'(WORDS + $urandom_range(0, 7935))
                                            : 16'($urandom_range(0, WORDS - 1));
            hcount_in   = 11'($urandom_range(0, 1279));
            wr_valid_in = v;
            wr_addr_in  = a;
            wr_data_in  = PW'($urandom);
            @(negedge clk_in);
            check("idle_ready", wr_ready_out, 1);
            check("idle_we", fb_we_out, v && (int'(a) < WORDS));
            if (v) begin
                check("wr_addr", fb_addr_out, a);
                check("wr_din", fb_din_out, wr_data_in);
                if (int'(a) < WORDS) ref_mem[a] = wr_data_in;
            end
            tick();
        end
        wr_valid_in = 1'b0;
    endtask

    task automatic run_fetch(input int vc, input bit wr_hold, input int ovr_col, input int rst_col);
        int            row;
        int            base;
        int            n_exp;
        logic [15:0]   hold_addr;
        logic [PW-1:0] hold_data;
        row   = (vc == 749) ? 0 : (vc + 1) / 4;
        base  = row * 320;
        n_exp = (rst_col >= 0) ? rst_col - LAT + 1 : 320;
        for (int c = 0; c < n_exp; c++)
            lbq.push_back({6'd0, 1'(row), 9'(c), ref_mem[base + c]});

        hold_addr   = 16'($urandom_range(0, WORDS - 1));
        hold_data   = PW'($urandom);
        vcount_in   = 10'(vc);
        hcount_in   = 11'd1280;
        wr_valid_in = wr_hold;
        wr_addr_in  = hold_addr;
        wr_data_in  = hold_data;
        @(negedge clk_in);
        check("trig_ready", wr_ready_out, 0);
        check("trig_we", fb_we_out, 0);
        check("disp_bank", disp_bank_out, vc[2]);
        tick();
        hcount_in = 11'd1281;

        for (int c = 0; c < 320; c++) begin
            if (c == ovr_col) hcount_in = 11'd1280;
            if (c == rst_col) rst_in = 1'b1;
            @(negedge clk_in);
            check("rd_addr", fb_addr_out, base + c);
            check("rd_we", fb_we_out, 0);
            check("busy_ready", wr_ready_out, 0);
            check("lb_we_timing", lb_we_out, c >= LAT);
            tick();
            hcount_in = 11'd1281;
            if (c == rst_col) begin
                rst_in      = 1'b0;
                wr_valid_in = 1'b0;
                hcount_in   = 11'd0;
                @(negedge clk_in);
                check("rst_fb_we", fb_we_out, 0);
                check("rst_fb_addr", fb_addr_out, 0);
                check("rst_lb_we", lb_we_out, 0);
                check("rst_lb_addr", lb_addr_out, 0);
                check("rst_overrun", overrun_out, 0);
                check("rst_ready", wr_ready_out, 1);
                tick();
                repeat (8) tick();
                check("lbq_empty", lbq.size(), 0);
                return;
            end
        end

        for (int d = 0; d < LAT; d++) begin
            @(negedge clk_in);
            check("drain_ready", wr_ready_out, 0);
            check("drain_we", fb_we_out, 0);
            check("drain_lb_we", lb_we_out, 1);
            tick();
        end

        hcount_in = 11'd0;
        @(negedge clk_in);
        check("resume_ready", wr_ready_out, 1);
        check("resume_lb_we", lb_we_out, 0);
        check("resume_we", fb_we_out, wr_hold);
        if (wr_hold) begin
            check("resume_addr", fb_addr_out, hold_addr);
            ref_mem[hold_addr] = hold_data;
        end
        tick();
        wr_valid_in = 1'b0;
        check("lbq_empty", lbq.size(), 0);
        if (ovr_col >= 0) check("overrun_set", overrun_out, 1);
    endtask

    initial begin
        rst_in      = 1'b1;
        hcount_in   = '0;
        vcount_in   = '0;
        wr_valid_in = 1'b0;
        wr_addr_in  = '0;
        wr_data_in  = '0;
        for (int i = 0; i < WORDS; i++)
            ref_mem[i] = seed_pix(i);
        repeat (3) tick();
        @(negedge clk_in);
        check("reset_ready", wr_ready_out, 0);
        check("reset_fb_we", fb_we_out, 0);
        check("reset_lb_we", lb_we_out, 0);
        check("reset_overrun", overrun_out, 0);
        check("reset_fb_addr", fb_addr_out, 0);
        check("reset_lb_addr", lb_addr_out, 0);
        rst_in = 1'b0;
        tick();

        idle_writes(40);
        run_fetch(3, 1'b1, -1, -1);
        idle_writes(5);
        run_fetch(749, 1'b0, -1, -1);
        idle_writes(5);
        run_fetch(715, 1'b1, -1, -1);
        check("no_overrun_yet", overrun_out, 0);

        run_fetch(7, 1'b0, 50, -1);
        idle_writes(3);
        check("overrun_sticky", overrun_out, 1);

        run_fetch(11, 1'b0, -1, 100);
        run_fetch(11, 1'b0, -1, -1);

        for (int v = 3; v < 719; v += 4) begin
            idle_writes(3);
            run_fetch(v, (v % 20) == 3, -1, -1);
        end
        idle_writes(3);
        run_fetch(749, 1'b0, -1, -1);
        check("frame_overrun", overrun_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/line_fetch_arbiter.md
LINE_FETCH_ARBITER -- requirements
Module: line_fetch_arbiter

Interface
REQ-001 Parameter: PIXEL_WIDTH, 16, framebuffer pixel width in bits.
REQ-002 Parameter: FB_LATENCY, 2, framebuffer read latency in cycles (address to data).
REQ-003 Ports (name  direction  width  meaning):
- clk_in  in  1  pixel clock; the only clock.
- rst_in  in  1  synchronous, active-high reset.
- hcount_in  in  11  720p horizontal count, 0..1649, active 0..1279.
- vcount_in  in  10  720p vertical count, 0..749, active 0..719.
- wr_valid_in  in  1  renderer write request.
- wr_addr_in  in  16  renderer write address, 0..57599.
- wr_data_in  in  PIXEL_WIDTH  renderer write pixel.
- wr_ready_out  out  1  write accepted when wr_valid_in && wr_ready_out.
- fb_addr_out  out  16  framebuffer port address.
- fb_we_out  out  1  framebuffer write enable.
- fb_din_out  out  PIXEL_WIDTH  framebuffer write data.
- fb_dout_in  in  PIXEL_WIDTH  framebuffer read data, valid FB_LATENCY cycles after address.
- lb_we_out  out  1  line-buffer write enable.
- lb_bank_out  out  1  line-buffer bank being filled.
- lb_addr_out  out  9  line-buffer column, 0..319.
- lb_data_out  out  PIXEL_WIDTH  line-buffer write data.
- disp_bank_out  out  1  bank the display reads, equal to vcount_in[2].
- overrun_out  out  1  sticky flag: a fetch trigger was missed.

Function
REQ-004 Source frame is 320x180, row-major, addr = row*320 + col; each source row feeds 4 display lines, each source pixel 4 display columns.
REQ-005 Fetch trigger: hcount_in == 1280 and ((vcount_in[1:0] == 3 and vcount_in < 719) or vcount_in == 749).
REQ-006 Fetch row on trigger: (vcount_in+1)>>2, or 0 when vcount_in == 749; the target bank is bit 0 of the fetch row.
REQ-007 States: IDLE, FETCH, DRAIN.
REQ-008 IDLE -> FETCH on trigger: latch row base address (row*320, computed without a multiplier, e.g. running base advanced by 320 per fetch and cleared on the vcount 749 fetch) and set column to 0.
REQ-009 FETCH: each cycle fb_we_out=0, fb_addr_out=base+col, col increments; after col 319 is issued -> DRAIN.
REQ-010 DRAIN lasts exactly FB_LATENCY cycles, then -> IDLE.
REQ-011 Line-buffer writes: a read issued in cycle t produces lb_we_out=1 in cycle t+FB_LATENCY with lb_addr_out=col, lb_bank_out=target bank, lb_data_out=fb_dout_in; there are exactly 320 consecutive lb_we_out pulses per fetch.
REQ-012 Fetch occupies 320+FB_LATENCY cycles, which SHALL fit inside the 370-cycle horizontal blank.
REQ-013 wr_ready_out = state==IDLE && !trigger && !rst_in (combinational); the fetch wins over a simultaneous write.
REQ-014 On an accepted write, in the same cycle: fb_we_out=1, fb_addr_out=wr_addr_in, fb_din_out=wr_data_in; there is at most one write per cycle.
REQ-015 When no read or write is in progress: fb_we_out=0; fb_addr_out and fb_din_out are don't-care but held at their last value.
REQ-016 A trigger while state != IDLE is ignored and sets overrun_out; overrun_out clears only on reset.
REQ-017 disp_bank_out = vcount_in[2], combinational. The bank filled for row r SHALL never equal the bank displayed while that fill is in progress.
REQ-018 wr_addr_in >= 57600 is accepted, but fb_we_out stays 0 (write dropped).

Reset
REQ-019 On rst_in high at a clock edge: state=IDLE; col, base and the latency pipeline cleared; lb_we_out=0, fb_we_out=0, overrun_out=0, fb_addr_out=0, lb_addr_out=0.
REQ-020 Reset mid-FETCH or mid-DRAIN aborts the fetch; no lb_we_out pulse SHALL occur in the cycles after reset.
REQ-021 The first trigger after reset starts a normal fetch; the base address is taken from the trigger row, not from stale state.

Verification
REQ-022 Trigger at vcount 3, hcount 1280 -> reads 320..639 issued on consecutive cycles; lb_we_out pulses 320 times on bank 1; lb_addr_out runs 0..319 with data matching the model.
REQ-023 Trigger at vcount 749 -> reads 0..319, bank 0; at vcount 715 -> reads 57280..57599, bank 1.
REQ-024 wr_valid_in held high across a trigger -> the write in the trigger cycle is not accepted; no writes during the 322 fetch cycles; writes resume the cycle after DRAIN ends.
REQ-025 Forced trigger (hcount 1280 re-applied) while in FETCH -> overrun_out=1 and the current fetch completes unchanged.
REQ-026 rst_in asserted at col 100 of a fetch -> all outputs at reset values the next cycle; no further lb_we_out; the next trigger fetches the correct row.
REQ-027 Full frame with random renderer writes -> each line-buffer row equals the reference framebuffer row; overrun_out stays 0.
